// File: rtl/core_memory_responder_if.sv
// Core-to-memory bundle: instruction fetch port plus data load/store port.
// master = core side, slave = memory responder side.
interface core_memory_responder_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0]   pc_to_mem;
    logic [DATA_W-1:0]   ld_data_for_inst;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   st_data;
    logic [DATA_W/8-1:0] we;
    logic [DATA_W-1:0]   ld_data;
    logic                oob_err;
    logic [ADDR_W-1:0]   oob_addr;

    modport master (
        output pc_to_mem, mem_addr, st_data, we,
        input  ld_data_for_inst, ld_data, oob_err, oob_addr
    );

    modport slave (
        input  pc_to_mem, mem_addr, st_data, we,
        output ld_data_for_inst, ld_data, oob_err, oob_addr
    );
endinterface

// File: rtl/core_memory_responder.sv
// Shared word RAM serving instruction fetch and data load/store, write-first forwarding.
// Latency: read data valid LOAD_LATENCY cycles after the address is presented.
// Backpressure: none; one address per port accepted every cycle.
module core_memory_responder #(
    parameter int DATA_W       = 64,
    parameter int ADDR_W       = 32,
    parameter int DEPTH_LOG2   = 12,
    parameter int LOAD_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    core_memory_responder_if.slave mem_if
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int NB    = DATA_W / 8;

    typedef logic [DEPTH_LOG2-1:0] idx_t;

    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     mask
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int b = 0; b < NB; b++) begin
            if (mask[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_W-1:0] ram [DEPTH];

    idx_t              d_idx;
    idx_t              i_idx;
    logic              d_in_range;
    logic              i_in_range;
    logic              wr_en;
    logic              i_hit;
    logic              d_oob;
    logic              i_oob;
    logic              unused_addr_bits;

    logic [DATA_W-1:0] d_ram_q;
    logic [DATA_W-1:0] i_ram_q;
    logic              d_vld_q;
    logic              i_vld_q;
    logic [NB-1:0]     d_fwd_q;
    logic [NB-1:0]     i_fwd_q;
    logic [DATA_W-1:0] st_q;
    logic [DATA_W-1:0] d_s1;
    logic [DATA_W-1:0] i_s1;
    logic              oob_err_q;
    logic [ADDR_W-1:0] oob_addr_q;

    assign d_idx      = mem_if.mem_addr[DEPTH_LOG2+2:3];
    assign i_idx      = mem_if.pc_to_mem[DEPTH_LOG2+2:3];
    assign d_in_range = (mem_if.mem_addr[ADDR_W-1:DEPTH_LOG2+3] == '0);
    assign i_in_range = (mem_if.pc_to_mem[ADDR_W-1:DEPTH_LOG2+3] == '0);

    // Byte offset inside the word is resolved by the core.
    assign unused_addr_bits = ^{mem_if.mem_addr[2:0], mem_if.pc_to_mem[2:0]};

    // Stores are dropped while in reset and when they fall outside the array.
    assign wr_en = rstn && d_in_range && (|mem_if.we);
    assign i_hit = wr_en && i_in_range && (i_idx == d_idx);

    // Data loads only count as out of range when they also store.
    assign d_oob = (|mem_if.we) && !d_in_range;
    assign i_oob = !i_in_range;

    // Port A: read/write, read-before-write. Port B: read only.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_if.we[b]) begin
                    ram[d_idx][8*b +: 8] <= mem_if.st_data[8*b +: 8];
                end
            end
        end
        d_ram_q <= ram[d_idx];
    end

    always_ff @(posedge clk) begin
        i_ram_q <= ram[i_idx];
    end

    // Forwarding sideband travels next to the RAM output register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d_vld_q <= 1'b0;
            i_vld_q <= 1'b0;
            d_fwd_q <= '0;
            i_fwd_q <= '0;
            st_q    <= '0;
        end else begin
            d_vld_q <= d_in_range;
            i_vld_q <= i_in_range;
            d_fwd_q <= wr_en ? mem_if.we : '0;
            i_fwd_q <= i_hit ? mem_if.we : '0;
            st_q    <= mem_if.st_data;
        end
    end

    assign d_s1 = d_vld_q ? merge_lanes(d_ram_q, st_q, d_fwd_q) : '0;
    assign i_s1 = i_vld_q ? merge_lanes(i_ram_q, st_q, i_fwd_q) : '0;

    generate
        if (LOAD_LATENCY == 1) begin : g_lat1
            assign mem_if.ld_data          = d_s1;
            assign mem_if.ld_data_for_inst = i_s1;
        end else begin : g_latn
            logic [DATA_W-1:0] d_dly [LOAD_LATENCY-1];
            logic [DATA_W-1:0] i_dly [LOAD_LATENCY-1];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int k = 0; k < LOAD_LATENCY-1; k++) begin
                        d_dly[k] <= '0;
                        i_dly[k] <= '0;
                    end
                end else begin
                    d_dly[0] <= d_s1;
                    i_dly[0] <= i_s1;
                    for (int k = 1; k < LOAD_LATENCY-1; k++) begin
                        d_dly[k] <= d_dly[k-1];
                        i_dly[k] <= i_dly[k-1];
                    end
                end
            end

            assign mem_if.ld_data          = d_dly[LOAD_LATENCY-2];
            assign mem_if.ld_data_for_inst = i_dly[LOAD_LATENCY-2];
        end
    endgenerate

    // Sticky error; the address is latched only on the first offence.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            oob_err_q  <= 1'b0;
            oob_addr_q <= '0;
        end else if (!oob_err_q && (d_oob || i_oob)) begin
            oob_err_q  <= 1'b1;
            oob_addr_q <= d_oob ? mem_if.mem_addr : mem_if.pc_to_mem;
        end
    end

    assign mem_if.oob_err  = oob_err_q;
    assign mem_if.oob_addr = oob_addr_q;
endmodule

// File: tb/tb_core_memory_responder.sv
// Bench for core_memory_responder: three instances (latency 1, 2, 3) share one stimulus
// stream and are compared against a word-array reference model every cycle.
module tb_core_memory_responder;
    localparam int AW = 32;
    localparam int DW = 64;

    logic        clk  = 1'b0;
    logic        rstn = 1'b1;
    logic [31:0] pc   = '0;
    logic [31:0] addr = '0;
    logic [63:0] st   = '0;
    logic [7:0]  we   = '0;

    always #5 clk = ~clk;

    core_memory_responder_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();
    core_memory_responder_if #(.DATA_W(DW), .ADDR_W(AW)) if2 ();
    core_memory_responder_if #(.DATA_W(DW), .ADDR_W(AW)) if3 ();

    assign if1.pc_to_mem = pc;
    assign if1.mem_addr  = addr;
    assign if1.st_data   = st;
    assign if1.we        = we;
    assign if2.pc_to_mem = pc;
    assign if2.mem_addr  = addr;
    assign if2.st_data   = st;
    assign if2.we        = we;
    assign if3.pc_to_mem = pc;
    assign if3.mem_addr  = addr;
    assign if3.st_data   = st;
    assign if3.we        = we;

    core_memory_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(12), .LOAD_LATENCY(1))
        dut1 (.clk(clk), .rstn(rstn), .mem_if(if1));
    core_memory_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(12), .LOAD_LATENCY(2))
        dut2 (.clk(clk), .rstn(rstn), .mem_if(if2));
    core_memory_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(12), .LOAD_LATENCY(3))
        dut3 (.clk(clk), .rstn(rstn), .mem_if(if3));

    // Reference model: word array plus the word each read returned, indexed by edge number.
    logic [63:0] mmem [4096];
    logic [63:0] hd   [8192];
    logic [63:0] hi   [8192];
    int          edge_cnt   = 0;
    int          last_bad   = 0;
    logic        m_oob      = 1'b0;
    logic [31:0] m_oob_addr = '0;
    int          checks     = 0;
    int          failures   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [63:0] st;
        logic [7:0]  we;
        logic [63:0] exp_d;
        logic [63:0] exp_i;
    } vec_t;

    vec_t vt [10];

    always @(negedge rstn) begin
        last_bad   = edge_cnt;
        m_oob      = 1'b0;
        m_oob_addr = '0;
    end

    function automatic logic [63:0] fill(input int w);
        return {16'hC0DE, w[15:0], 16'hF00D, w[15:0]};
    endfunction

    task automatic model_edge();
        int          di;
        int          ii;
        bit          d_in;
        bit          i_in;
        bit          st_ok;
        logic [63:0] nw;
        edge_cnt++;
        if (!rstn) begin
            last_bad = edge_cnt;
            return;
        end
        d_in  = (addr < 32'h0000_8000);
        i_in  = (pc < 32'h0000_8000);
        di    = d_in ? int'(addr >> 3) : 0;
        ii    = i_in ? int'(pc >> 3) : 0;
        st_ok = d_in && (we != 8'h00);
        nw    = d_in ? mmem[di] : 64'h0;
        for (int b = 0; b < 8; b++) begin
            if (we[b]) nw[8*b +: 8] = st[8*b +: 8];
        end
        hd[edge_cnt] = d_in ? nw : 64'h0;
        hi[edge_cnt] = !i_in ? 64'h0 : ((st_ok && ii == di) ? nw : mmem[ii]);
        if (st_ok) mmem[di] = nw;
        if (!m_oob) begin
            if (we != 8'h00 && !d_in) begin
                m_oob      = 1'b1;
                m_oob_addr = addr;
            end else if (!i_in) begin
                m_oob      = 1'b1;
                m_oob_addr = pc;
            end
        end
    endtask

    function automatic logic [63:0] exp_out(input int lat, input bit inst);
        int src;
        src = edge_cnt - lat + 1;
        if (src < 1 || src <= last_bad) return 64'h0;
        return inst ? hi[src] : hd[src];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic check_port(input string tag, input int lat, input logic [63:0] ld,
                              input logic [63:0] inst, input logic oe, input logic [31:0] oa);
        chk({tag, " ld_data"}, ld, exp_out(lat, 1'b0));
        chk({tag, " ld_data_for_inst"}, inst, exp_out(lat, 1'b1));
        chk({tag, " oob_err"}, 64'(oe), 64'(m_oob));
        chk({tag, " oob_addr"}, 64'(oa), 64'(m_oob_addr));
    endtask

    task automatic check_all();
        check_port("L1", 1, if1.ld_data, if1.ld_data_for_inst, if1.oob_err, if1.oob_addr);
        check_port("L2", 2, if2.ld_data, if2.ld_data_for_inst, if2.oob_err, if2.oob_addr);
        check_port("L3", 3, if3.ld_data, if3.ld_data_for_inst, if3.oob_err, if3.oob_addr);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_in(input logic [31:0] p, input logic [31:0] a,
                          input logic [63:0] s, input logic [7:0] w);
        pc   = p;
        addr = a;
        st   = s;
        we   = w;
    endtask

    initial begin
        vt[0] = '{32'h40, 32'h40, 64'h0123_4567_89AB_CDEF, 8'hFF,
                  64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
        vt[1] = '{32'h48, 32'h40, 64'h0, 8'h00,
                  64'h0123_4567_89AB_CDEF, 64'hC0DE_0009_F00D_0009};
        vt[2] = '{32'h00, 32'h45, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0C,
                  64'h0123_4567_FFFF_CDEF, 64'hC0DE_0000_F00D_0000};
        vt[3] = '{32'h40, 32'h40, 64'h0, 8'h00,
                  64'h0123_4567_FFFF_CDEF, 64'h0123_4567_FFFF_CDEF};
        vt[4] = '{32'h88, 32'h80, 64'h1111_2222_3333_4444, 8'hFF,
                  64'h1111_2222_3333_4444, 64'hC0DE_0011_F00D_0011};
        vt[5] = '{32'h80, 32'h80, 64'hDEAD_BEEF_0000_0000, 8'hF0,
                  64'hDEAD_BEEF_3333_4444, 64'hDEAD_BEEF_3333_4444};
        vt[6] = '{32'h84, 32'h87, 64'h0, 8'h00,
                  64'hDEAD_BEEF_3333_4444, 64'hDEAD_BEEF_3333_4444};
        vt[7] = '{32'h80, 32'h88, 64'h0000_0000_0000_00AB, 8'h01,
                  64'hC0DE_0011_F00D_00AB, 64'hDEAD_BEEF_3333_4444};
        vt[8] = '{32'h88, 32'h88, 64'h0, 8'h00,
                  64'hC0DE_0011_F00D_00AB, 64'hC0DE_0011_F00D_00AB};
        vt[9] = '{32'h90, 32'h90, 64'h7700_0000_0000_0000, 8'h80,
                  64'h77DE_0012_F00D_0012, 64'h77DE_0012_F00D_0012};

        #2 rstn = 1'b0;
        repeat (3) tick();
        #4 rstn = 1'b1;

        for (int w = 0; w < 64; w++) begin
            set_in(32'(w * 8), 32'(w * 8), fill(w), 8'hFF);
            tick();
        end

        // Directed vectors against the latency-1 instance.
        for (int i = 0; i < 10; i++) begin
            set_in(vt[i].pc, vt[i].addr, vt[i].st, vt[i].we);
            tick();
            chk($sformatf("vec%0d ld_data", i), if1.ld_data, vt[i].exp_d);
            chk($sformatf("vec%0d ld_data_for_inst", i), if1.ld_data_for_inst, vt[i].exp_i);
        end

        // Back-to-back reads through the latency-3 instance.
        set_in(32'h0, 32'h00, 64'h0, 8'h00); tick();
        set_in(32'h0, 32'h08, 64'h0, 8'h00); tick();
        set_in(32'h0, 32'h10, 64'h0, 8'h00); tick();
        chk("sweep word0", if3.ld_data, fill(0));
        set_in(32'h0, 32'h18, 64'h0, 8'h00); tick();
        chk("sweep word1", if3.ld_data, fill(1));
        set_in(32'h0, 32'h20, 64'h0, 8'h00); tick();
        chk("sweep word2", if3.ld_data, fill(2));

        // Out-of-range store must not alias onto word 0.
        set_in(32'h0, 32'h0000_8000, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF); tick();
        chk("oob err set", 64'(if1.oob_err), 64'h1);
        chk("oob addr", 64'(if1.oob_addr), 64'h8000);
        chk("oob store read", if1.ld_data, 64'h0);
        set_in(32'h0, 32'h0000_0000, 64'h0, 8'h00); tick();
        chk("word0 intact", if1.ld_data, fill(0));
        set_in(32'h0, 32'h0000_8000, 64'h0, 8'h00); tick();
        chk("oob read zero", if1.ld_data, 64'h0);
        set_in(32'h0001_0000, 32'h40, 64'h0, 8'h00); tick();
        chk("oob addr held", 64'(if1.oob_addr), 64'h8000);
        chk("oob inst zero", if1.ld_data_for_inst, 64'h0);

        // Reset with a read in flight on the latency-2 instance.
        set_in(32'h0, 32'h40, 64'h0, 8'h00); tick();
        #4 rstn = 1'b0;
        set_in(32'h0, 32'h40, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        #1;
        chk("rst ld immediate", if2.ld_data, 64'h0);
        chk("rst oob immediate", 64'(if2.oob_err), 64'h0);
        tick();
        tick();
        #4 rstn = 1'b1;
        set_in(32'h0, 32'h40, 64'h0, 8'h00);
        tick();
        chk("rst first edge ld", if2.ld_data, 64'h0);
        chk("rst first edge oob", 64'(if2.oob_err), 64'h0);
        tick();
        chk("rst preserved", if2.ld_data, 64'h0123_4567_FFFF_CDEF);

        // Random traffic over a small word window for frequent collisions.
        for (int n = 0; n < 1500; n++) begin
            addr = 32'($urandom_range(0, 15) * 8) + 32'($urandom_range(0, 7));
            pc   = 32'($urandom_range(0, 15) * 8) + 32'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) addr = $urandom | 32'h0000_8000;
            if ($urandom_range(0, 31) == 0) pc = $urandom | 32'h0000_8000;
            we = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
            st = {$urandom, $urandom};
            if (n == 700) #2 rstn = 1'b0;
            if (n == 702) #2 rstn = 1'b1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/core_memory_responder.md
Name: core_memory_responder

Overview:
- Memory-side responder for the core's two memory ports: the instruction-fetch port (pc_to_mem in, ld_data_for_inst out) and the data port (mem_addr, st_data, we in, ld_data out).
- Holds a single shared word array of 2**DEPTH_LOG2 64-bit words.
- Returns read data exactly LOAD_LATENCY cycles after the address is presented.
- Applies byte-enabled stores, forwards same-cycle stores into reads, and flags out-of-range accesses.

Parameters:
- DATA_W, 64: word width in bits; must be 64.
- ADDR_W, 32: byte-address width.
- DEPTH_LOG2, 12: log2 of the word count; 4096 words = 32 KiB.
- LOAD_LATENCY, 1: read latency in cycles; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- pc_to_mem  in  ADDR_W  instruction byte address; read every cycle.
- ld_data_for_inst  out  DATA_W  instruction word for pc_to_mem from LOAD_LATENCY cycles earlier.
- mem_addr  in  ADDR_W  data byte address; read every cycle, written when we != 0.
- st_data  in  DATA_W  store data, already byte-lane aligned.
- we  in  DATA_W/8  byte write enables.
- ld_data  out  DATA_W  data word for mem_addr from LOAD_LATENCY cycles earlier.
- oob_err  out  1  sticky out-of-range flag.
- oob_addr  out  ADDR_W  byte address of the first out-of-range access.

Behaviour:
- Word index:
  - Word index = addr[DEPTH_LOG2+2:3].
  - addr[2:0] is ignored; the core selects the byte itself.
  - In range iff addr[ADDR_W-1:DEPTH_LOG2+3] == 0.
- Byte lanes are big-endian within a word:
  - we[i] writes st_data[8i+7:8i].
  - Byte offset 0 lives in bits [63:56], i.e. lane 7.
- Store timing:
  - A store presented in cycle N updates the array at the rising edge ending cycle N.
  - Lanes with we[i]=0 are untouched.
  - we=8'h00 means no write; mem_addr still performs a read.
- Read pipeline, per port:
  - Stage 1 registers the array word (or the forwarded word) at the edge ending cycle N.
  - Stages 2..LOAD_LATENCY are plain delay registers.
  - The output equals the last stage, so data is visible during cycle N+LOAD_LATENCY.
- Forwarding (write-first):
  - If the read address of either port in cycle N hits the same in-range word as the store in cycle N, the returned word is per-byte: st_data where we[i]=1, old contents elsewhere.
  - Applies to both the data and instruction ports, covering self-modifying code.
  - A store in cycle N+1 or later does not affect a read issued in cycle N; that read returns the value as of cycle N.
- Out-of-range accesses:
  - A read returns 64'h0 at normal latency.
  - A store is dropped; the array is unchanged.
  - A data port access counts only when it is a store (we != 0).
  - Either condition sets oob_err. oob_addr captures the offending address only on the 0->1 transition of oob_err.
  - If both ports are out of range in the same cycle, the data port address wins.
  - oob_err is cleared only by reset.
- Reset (asynchronous, rstn low):
  - All pipeline stages, ld_data, ld_data_for_inst, oob_err and oob_addr go to 0 immediately.
  - Array contents are not reset; they are preserved across reset.
  - A store presented during the cycle rstn is low is ignored.
  - Reads in flight when reset asserts are discarded.
  - After rstn rises, outputs stay 0 until the first post-reset read reaches the last stage, LOAD_LATENCY edges later.
- Both ports read the same word in the same cycle: both return identical data.
- No stall input: the responder accepts one address per port every cycle, with no backpressure.
- Address wrap: none. High address bits beyond the array are out of range, never aliased.
- Storage must infer as a dual-port block RAM: one read/write port and one read port, with forwarding implemented outside the RAM.

Test Plan:
- Basic store/load:
  - Stimulus: LOAD_LATENCY=1; cycle 0 store 64'h0123_4567_89AB_CDEF to addr 0x40 with we=8'hFF; cycle 1 read 0x40.
  - Required: ld_data = 64'h0123_4567_89AB_CDEF during cycle 2.
- Partial store:
  - Stimulus: after the above, store st_data=64'hFFFF_FFFF_FFFF_FFFF to 0x45 with we=8'h0C; then read 0x40.
  - Required: ld_data = 64'h0123_4567_FFFF_CDEF.
- Same-cycle forwarding:
  - Stimulus: cycle N, store 64'hDEAD_BEEF_0000_0000 with we=8'hF0 to 0x80 (old contents 64'h1111_2222_3333_4444), while pc_to_mem=0x80.
  - Required: ld_data_for_inst = 64'hDEAD_BEEF_3333_4444 and ld_data equal to it, both at cycle N+1.
- Latency sweep:
  - Stimulus: LOAD_LATENCY=3; issue back-to-back reads of 0x00, 0x08, 0x10 holding distinct words.
  - Required: the words appear on consecutive cycles starting 3 cycles after the first read; no bubbles, no duplicates.
- Out of range (DEPTH_LOG2=12):
  - Stimulus: store to 0x0000_8000 with we=8'hFF, then read 0x0000_0000.
  - Required: oob_err=1 from the next cycle with oob_addr=0x0000_8000; word 0 unchanged; a read of 0x8000 returns 64'h0.
- Reset mid-flight:
  - Stimulus: LOAD_LATENCY=2; read 0x40, then assert rstn low one cycle later for 2 cycles.
  - Required: ld_data=0 and oob_err=0 immediately on reset and through the first post-reset edge; a read of 0x40 after release returns the pre-reset contents 2 cycles later.
